// File: rtl/div_check_mul_if.sv
// Handshake and operand/result bundle for the div_check_mul block.
interface div_check_mul_if #(
  parameter int unsigned DW = 8
);
  logic              en;
  logic              start;
  logic [DW-1:0]     quotient;
  logic [DW-1:0]     divisor;
  logic [DW-1:0]     remainder;
  logic              busy;
  logic              done;
  logic [2*DW-1:0]   product;
  logic              div_err;

  modport master (
    output en, start, quotient, divisor, remainder,
    input  busy, done, product, div_err
  );

  modport slave (
    input  en, start, quotient, divisor, remainder,
    output busy, done, product, div_err
  );
endinterface

// File: rtl/div_check_mul.sv
// Sequential shift-add reconstruction of a dividend: product = quotient*divisor + remainder.
// Also flags non-canonical division results (zero divisor or remainder >= divisor).
module div_check_mul #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  div_check_mul_if.slave bus
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned CW = (DW > 2) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   acc, acc_n;
  logic [PW-1:0]   mcand, mcand_n;
  logic [DW-1:0]   mplier, mplier_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            err_r, err_r_n;
  logic [PW-1:0]   product_q, product_n;
  logic            div_err_q, div_err_n;
  logic            busy_q, busy_n;
  logic            done_q, done_n;
  logic [PW-1:0]   sum;

  // Registered state and datapath; everything holds while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      err_r     <= 1'b0;
      product_q <= '0;
      div_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (bus.en) begin
      state     <= state_n;
      acc       <= acc_n;
      mcand     <= mcand_n;
      mplier    <= mplier_n;
      cnt       <= cnt_n;
      err_r     <= err_r_n;
      product_q <= product_n;
      div_err_q <= div_err_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
    end
  end

  // Next-state and datapath: one multiplier bit consumed per CALC cycle.
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    mcand_n   = mcand;
    mplier_n  = mplier;
    cnt_n     = cnt;
    err_r_n   = err_r;
    product_n = product_q;
    div_err_n = div_err_q;
    sum       = mplier[0] ? (acc + mcand) : acc;

    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_n    = {{DW{1'b0}}, bus.remainder};
          mcand_n  = {{DW{1'b0}}, bus.divisor};
          mplier_n = bus.quotient;
          cnt_n    = '0;
          err_r_n  = (bus.divisor == '0) | (bus.remainder >= bus.divisor);
          state_n  = CALC;
        end
      end
      CALC: begin
        acc_n    = sum;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + CW'(1);
        if (cnt == CW'(DW - 1)) begin
          product_n = sum;
          div_err_n = err_r;
          state_n   = DONE;
        end
      end
      DONE: begin
        // A start arriving here is intentionally dropped.
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.div_err = div_err_q;

endmodule

// File: tb/tb_div_check_mul.sv
// Randomized and directed bench for div_check_mul with a cycle-level behavioural model.
module tb_div_check_mul;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 2 * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   cmp_on = 1'b0;

  div_check_mul_if #(.DW(DW)) bus ();

  div_check_mul #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: counts enabled edges since accept, result from plain arithmetic.
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic [PW-1:0] m_prod = '0;
  logic          m_err  = 1'b0;
  logic [PW-1:0] e_prod = '0;
  logic          e_err  = 1'b0;
  int            k = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_prod = '0;
      m_err  = 1'b0;
      k      = 0;
    end else if (bus.en) begin
      if (!m_busy) begin
        if (bus.start) begin
          e_prod = PW'(int'(bus.quotient) * int'(bus.divisor) + int'(bus.remainder));
          e_err  = (bus.divisor == 0) || (bus.remainder >= bus.divisor);
          m_busy = 1'b1;
          k      = 0;
        end
      end else begin
        k = k + 1;
        if (k == DW) begin
          m_done = 1'b1;
          m_prod = e_prod;
          m_err  = e_err;
        end else if (k == DW + 1) begin
          m_done = 1'b0;
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_on && !rst) begin
      chk("busy",    64'(bus.busy),    64'(m_busy));
      chk("done",    64'(bus.done),    64'(m_done));
      chk("product", 64'(bus.product), 64'(m_prod));
      chk("div_err", 64'(bus.div_err), 64'(m_err));
    end
  end

  // Issue one operation and wait for it to finish; returns result and busy-cycle count.
  task automatic run_op(input logic [DW-1:0] q, input logic [DW-1:0] d, input logic [DW-1:0] r,
                        input bit hammer, input bit toggle_en,
                        output logic [PW-1:0] p, output logic e, output int bc);
    bit seen;
    seen = 1'b0;
    bc = 0;
    p = '0;
    e = 1'b0;
    bus.en = 1'b1;
    bus.start = 1'b1;
    bus.quotient = q;
    bus.divisor = d;
    bus.remainder = r;
    @(negedge clk);
    bus.start = 1'b0;
    bus.quotient = DW'($urandom);
    bus.divisor = DW'($urandom);
    bus.remainder = DW'($urandom);
    for (int i = 0; i < 60; i++) begin
      if (bus.busy) bc++;
      if (bus.done) begin
        seen = 1'b1;
        p = bus.product;
        e = bus.div_err;
      end
      if (seen && !bus.busy) break;
      if (hammer && bus.busy) begin
        bus.start = 1'b1;
        bus.quotient = DW'($urandom);
        bus.divisor = DW'($urandom);
        bus.remainder = DW'($urandom);
      end
      if (toggle_en) bus.en = ~bus.en;
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.en = 1'b1;
    if (!seen || bus.busy) begin
      errors++;
      checks++;
      $display("FAIL timeout: done seen=%0d busy=%0d required done and idle", seen, bus.busy);
    end
  endtask

  logic [PW-1:0] p;
  logic          e;
  int            bc;

  initial begin
    bus.en = 1'b1;
    bus.start = 1'b0;
    bus.quotient = '0;
    bus.divisor = '0;
    bus.remainder = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_on = 1'b1;
    @(negedge clk);
    chk("reset_busy",    64'(bus.busy),    64'd0);
    chk("reset_product", 64'(bus.product), 64'd0);

    // Directed vectors with hand-computed results.
    run_op(8'd13, 8'd12, 8'd5, 1'b0, 1'b0, p, e, bc);
    chk("t1_product", 64'(p), 64'd161);
    chk("t1_err",     64'(e), 64'd0);
    chk("t1_busy_cycles", 64'(bc), 64'd9);
    @(negedge clk);
    run_op(8'd255, 8'd255, 8'd254, 1'b0, 1'b0, p, e, bc);
    chk("max_product", 64'(p), 64'hFEFF);
    chk("max_err",     64'(e), 64'd0);
    @(negedge clk);
    run_op(8'd0, 8'd7, 8'd3, 1'b0, 1'b0, p, e, bc);
    chk("q0_product", 64'(p), 64'd3);
    chk("q0_err",     64'(e), 64'd0);
    @(negedge clk);
    run_op(8'd9, 8'd0, 8'd4, 1'b0, 1'b0, p, e, bc);
    chk("d0_product", 64'(p), 64'd4);
    chk("d0_err",     64'(e), 64'd1);
    @(negedge clk);
    run_op(8'd2, 8'd5, 8'd5, 1'b0, 1'b0, p, e, bc);
    chk("r_eq_d_product", 64'(p), 64'd15);
    chk("r_eq_d_err",     64'(e), 64'd1);

    // Start hammered while busy: only the first operands count.
    @(negedge clk);
    run_op(8'd100, 8'd3, 8'd2, 1'b1, 1'b0, p, e, bc);
    chk("hammer_product", 64'(p), 64'd302);
    chk("hammer_err",     64'(e), 64'd0);
    chk("hammer_busy_cycles", 64'(bc), 64'd9);

    // Clock enable toggling during CALC and DONE.
    @(negedge clk);
    run_op(8'd13, 8'd12, 8'd5, 1'b0, 1'b1, p, e, bc);
    chk("stall_product", 64'(p), 64'd161);
    chk("stall_err",     64'(e), 64'd0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    bus.start = 1'b1;
    bus.quotient = 8'd77;
    bus.divisor = 8'd9;
    bus.remainder = 8'd8;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",    64'(bus.busy),    64'd0);
    chk("arst_done",    64'(bus.done),    64'd0);
    chk("arst_err",     64'(bus.div_err), 64'd0);
    chk("arst_product", 64'(bus.product), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(8'd77, 8'd9, 8'd8, 1'b0, 1'b0, p, e, bc);
    chk("post_rst_product", 64'(p), 64'd701);
    chk("post_rst_err",     64'(e), 64'd0);

    // Randomized operations with random stalls and idle gaps, checked by the model.
    for (int n = 0; n < 60; n++) begin
      bus.quotient = DW'($urandom);
      bus.divisor = ($urandom_range(0, 7) == 0) ? DW'(0) : DW'($urandom);
      bus.remainder = DW'($urandom);
      bus.start = ($urandom_range(0, 2) != 0);
      bus.en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      for (int c = 0; c < 30; c++) begin
        bus.start = ($urandom_range(0, 3) == 0);
        bus.quotient = DW'($urandom);
        bus.divisor = DW'($urandom);
        bus.remainder = DW'($urandom);
        bus.en = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (!bus.busy && !m_busy) break;
      end
    end
    bus.start = 1'b0;
    bus.en = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
